// File: rtl/fp_class_unit_pkg.sv
// ---------------------------------------------------------------------------
// fp_class_unit_pkg
// Shared definitions for the single-precision decode path:
//   - op encodings for FCLASS.S, FMV.X.W and raw sign read
//   - FCLASS result bit indices (0..9)
//   - exponent all-ones constant
//   - the S1 field-flag struct and the helper that extracts it from an operand
// ---------------------------------------------------------------------------
package fp_class_unit_pkg;

   localparam logic [1:0] OP_FCLASS = 2'b00;
   localparam logic [1:0] OP_FMVXW  = 2'b01;
   localparam logic [1:0] OP_SIGN   = 2'b10;

   localparam int unsigned CLS_NEG_INF  = 0;
   localparam int unsigned CLS_NEG_NORM = 1;
   localparam int unsigned CLS_NEG_SUB  = 2;
   localparam int unsigned CLS_NEG_ZERO = 3;
   localparam int unsigned CLS_POS_ZERO = 4;
   localparam int unsigned CLS_POS_SUB  = 5;
   localparam int unsigned CLS_POS_NORM = 6;
   localparam int unsigned CLS_POS_INF  = 7;
   localparam int unsigned CLS_SNAN     = 8;
   localparam int unsigned CLS_QNAN     = 9;
   localparam int unsigned CLS_WIDTH    = 10;

   localparam logic [7:0] EXP_ONES = 8'hFF;

   typedef struct packed {
      logic sign;
      logic exp_ones;
      logic exp_zero;
      logic man_zero;
      logic man_msb;
   } fp_flags_t;

   function automatic fp_flags_t decode_fields(input logic [31:0] num);
      fp_flags_t f;
      f.sign     = num[31];
      f.exp_ones = (num[30:23] == EXP_ONES);
      f.exp_zero = (num[30:23] == 8'h00);
      f.man_zero = (num[22:0] == 23'h0);
      f.man_msb  = num[22];
      return f;
   endfunction

endpackage

// File: rtl/fp_class_decode.sv
// ---------------------------------------------------------------------------
// fp_class_decode
// Purely combinational FCLASS.S mask generation from pre-decoded fields.
// Exactly one bit of class_mask_o is set for any combination of flags that
// can come from a real operand.
// Ports:
//   sign_i        operand sign bit
//   exp_ones_i    exponent field is all ones
//   exp_zero_i    exponent field is zero
//   man_zero_i    mantissa field is zero
//   man_msb_i     mantissa bit 22 (quiet bit)
//   class_mask_o  10-bit one-hot class
// ---------------------------------------------------------------------------
module fp_class_decode
   import fp_class_unit_pkg::*;
(
   input  logic                 sign_i,
   input  logic                 exp_ones_i,
   input  logic                 exp_zero_i,
   input  logic                 man_zero_i,
   input  logic                 man_msb_i,
   output logic [CLS_WIDTH-1:0] class_mask_o
);

   always_comb begin
      class_mask_o = '0;
      if (exp_ones_i) begin
         if (man_zero_i) begin
            if (sign_i) class_mask_o[CLS_NEG_INF] = 1'b1;
            else        class_mask_o[CLS_POS_INF] = 1'b1;
         end else begin
            // NaN classes ignore the sign; the quiet bit picks q vs s.
            if (man_msb_i) class_mask_o[CLS_QNAN] = 1'b1;
            else           class_mask_o[CLS_SNAN] = 1'b1;
         end
      end else if (exp_zero_i) begin
         if (man_zero_i) begin
            if (sign_i) class_mask_o[CLS_NEG_ZERO] = 1'b1;
            else        class_mask_o[CLS_POS_ZERO] = 1'b1;
         end else begin
            if (sign_i) class_mask_o[CLS_NEG_SUB] = 1'b1;
            else        class_mask_o[CLS_POS_SUB] = 1'b1;
         end
      end else begin
         if (sign_i) class_mask_o[CLS_NEG_NORM] = 1'b1;
         else        class_mask_o[CLS_POS_NORM] = 1'b1;
      end
   end

endmodule

// File: rtl/fp_class_unit.sv
// ---------------------------------------------------------------------------
// fp_class_unit
// Two-stage pipelined decode of a single-precision operand into a 64-bit
// integer-side result: FCLASS.S, FMV.X.W or raw sign read.
// Ports:
//   in_clk      clock, rising edge
//   in_rst      synchronous active-high reset
//   in_valid    operand/op/tag valid
//   out_ready   block accepts input this cycle
//   in_num      32-bit operand
//   in_ctrl_op  00 FCLASS.S, 01 FMV.X.W, 10 sign read, 11 treated as FCLASS.S
//   in_tag      destination tag, passed through
//   out_valid   result valid
//   in_ready    downstream accepts the result
//   out_data    64-bit result
//   out_tag     tag aligned with out_data
//   out_busy    any stage holds a valid entry
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. out_ready depends only on in_ready and registered state, never
// on in_valid. While out_valid is high and in_ready is low, out_data and
// out_tag hold; a stage advances when the stage after it is empty or
// draining, so a full pipe can accept and emit in the same cycle.
// ---------------------------------------------------------------------------
module fp_class_unit
   import fp_class_unit_pkg::*;
(
   input  logic        in_clk,
   input  logic        in_rst,
   input  logic        in_valid,
   output logic        out_ready,
   input  logic [31:0] in_num,
   input  logic [1:0]  in_ctrl_op,
   input  logic [4:0]  in_tag,
   output logic        out_valid,
   input  logic        in_ready,
   output logic [63:0] out_data,
   output logic [4:0]  out_tag,
   output logic        out_busy
);

   // S1: operand, op, tag and decoded field flags
   logic            s1_valid_q, s1_valid_d;
   logic [31:0]     s1_num_q,   s1_num_d;
   logic [1:0]      s1_op_q,    s1_op_d;
   logic [4:0]      s1_tag_q,   s1_tag_d;
   fp_flags_t       s1_flags_q, s1_flags_d;

   // S2: formed result and tag
   logic            s2_valid_q, s2_valid_d;
   logic [63:0]     s2_data_q,  s2_data_d;
   logic [4:0]      s2_tag_q,   s2_tag_d;

   logic            adv1, adv2, take;
   logic [CLS_WIDTH-1:0] class_mask;
   logic [63:0]     result;

   fp_class_decode u_decode (
      .sign_i       (s1_flags_q.sign),
      .exp_ones_i   (s1_flags_q.exp_ones),
      .exp_zero_i   (s1_flags_q.exp_zero),
      .man_zero_i   (s1_flags_q.man_zero),
      .man_msb_i    (s1_flags_q.man_msb),
      .class_mask_o (class_mask)
   );

   // Result mux; the reserved op code falls through to FCLASS.S.
   always_comb begin
      result = {{(64 - CLS_WIDTH){1'b0}}, class_mask};
      case (s1_op_q)
         OP_FMVXW: result = {{32{s1_num_q[31]}}, s1_num_q};
         OP_SIGN:  result = {63'b0, s1_flags_q.sign};
         default:  result = {{(64 - CLS_WIDTH){1'b0}}, class_mask};
      endcase
   end

   always_comb begin
      adv2 = !s2_valid_q || in_ready;
      adv1 = !s1_valid_q || adv2;
      take = in_valid && adv1;

      s1_valid_d = s1_valid_q;
      s1_num_d   = s1_num_q;
      s1_op_d    = s1_op_q;
      s1_tag_d   = s1_tag_q;
      s1_flags_d = s1_flags_q;
      if (adv1) s1_valid_d = in_valid;
      if (take) begin
         s1_num_d   = in_num;
         s1_op_d    = in_ctrl_op;
         s1_tag_d   = in_tag;
         s1_flags_d = decode_fields(in_num);
      end

      s2_valid_d = s2_valid_q;
      s2_data_d  = s2_data_q;
      s2_tag_d   = s2_tag_q;
      // An empty S1 moving into S2 leaves a bubble, not a repeat.
      if (adv2) s2_valid_d = s1_valid_q;
      if (adv2 && s1_valid_q) begin
         s2_data_d = result;
         s2_tag_d  = s1_tag_q;
      end
   end

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         s1_valid_q <= 1'b0;
         s1_num_q   <= '0;
         s1_op_q    <= '0;
         s1_tag_q   <= '0;
         s1_flags_q <= '0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_tag_q   <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_num_q   <= s1_num_d;
         s1_op_q    <= s1_op_d;
         s1_tag_q   <= s1_tag_d;
         s1_flags_q <= s1_flags_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
         s2_tag_q   <= s2_tag_d;
      end
   end

   assign out_ready = adv1;
   assign out_valid = s2_valid_q;
   assign out_data  = s2_data_q;
   assign out_tag   = s2_tag_q;
   assign out_busy  = s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_fp_class_unit.sv
// ---------------------------------------------------------------------------
// tb_fp_class_unit
// Self-checking bench: directed FCLASS/NaN/FMV/sign cases, backpressure,
// random valid/ready sweep against a reference model, reset mid-stream.
// Expected results are queued at input acceptance and compared by a
// monitor when the DUT transfers a result.
// ---------------------------------------------------------------------------
module tb_fp_class_unit;

   logic        in_clk = 1'b0;
   logic        in_rst;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] in_num;
   logic [1:0]  in_ctrl_op;
   logic [4:0]  in_tag;
   logic        out_valid;
   logic        in_ready;
   logic [63:0] out_data;
   logic [4:0]  out_tag;
   logic        out_busy;

   int checks = 0;
   int errors = 0;
   logic [4:0]  tag_ctr = '0;

   logic [63:0] exp_q[$];
   logic [4:0]  exp_tag_q[$];

   logic [31:0] specials [8] = '{32'hFF800000, 32'h7F800000, 32'h7FC00000, 32'h7F800001,
                                 32'h80000000, 32'h00000000, 32'h807FFFFF, 32'h00000001};

   // ---------------- clock ----------------
   always #5 in_clk = ~in_clk;

   fp_class_unit dut (
      .in_clk     (in_clk),
      .in_rst     (in_rst),
      .in_valid   (in_valid),
      .out_ready  (out_ready),
      .in_num     (in_num),
      .in_ctrl_op (in_ctrl_op),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_tag    (out_tag),
      .out_busy   (out_busy)
   );

   // ---------------- reference model ----------------
   function automatic logic [63:0] model(input logic [31:0] n, input logic [1:0] op);
      logic [9:0]  m;
      logic [7:0]  e;
      logic [22:0] f;
      logic        s;
      s = n[31];
      e = n[30:23];
      f = n[22:0];
      if (op == 2'b01) return {{32{s}}, n};
      if (op == 2'b10) return {63'b0, s};
      if (e == 8'hFF && f == 23'h0)      m = s ? 10'h001 : 10'h080;
      else if (e == 8'hFF)               m = f[22] ? 10'h200 : 10'h100;
      else if (e == 8'h00 && f == 23'h0) m = s ? 10'h008 : 10'h010;
      else if (e == 8'h00)               m = s ? 10'h004 : 10'h020;
      else                               m = s ? 10'h002 : 10'h040;
      return {54'b0, m};
   endfunction

   // ---------------- scoreboard monitor ----------------
   // Sampled at the falling edge: a transfer seen here completes on the next rising edge.
   always @(negedge in_clk) begin
      if (!in_rst && out_valid && in_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_extra: unexpected result %h tag %0d", out_data, out_tag);
         end else begin
            logic [63:0] ed;
            logic [4:0]  et;
            ed = exp_q.pop_front();
            et = exp_tag_q.pop_front();
            if (out_data !== ed || out_tag !== et) begin
               errors++;
               $display("FAIL scoreboard_result: got %h tag %0d, expected %h tag %0d",
                        out_data, out_tag, ed, et);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Tasks start and end 1 time unit after a rising edge.
   task automatic drive_op(input logic [31:0] num, input logic [1:0] op, input logic [63:0] exp_d);
      bit acc = 0;
      in_valid   = 1'b1;
      in_num     = num;
      in_ctrl_op = op;
      in_tag     = tag_ctr;
      for (int i = 0; i < 64 && !acc; i++) begin
         @(negedge in_clk);
         if (out_ready) begin
            exp_q.push_back(exp_d);
            exp_tag_q.push_back(tag_ctr);
            acc = 1;
         end
         @(posedge in_clk); #1;
      end
      checks++;
      if (!acc) begin
         errors++;
         $display("FAIL accept_timeout: operand %h not accepted within 64 cycles, out_ready=%b", num, out_ready);
      end
      tag_ctr++;
   endtask

   task automatic wait_drain(input string name);
      in_valid = 1'b0;
      in_ready = 1'b1;
      for (int i = 0; i < 200 && (exp_q.size() != 0 || out_busy); i++) begin
         @(posedge in_clk); #1;
      end
      checks++;
      if (exp_q.size() != 0 || out_busy !== 1'b0) begin
         errors++;
         $display("FAIL drain_%s: %0d results outstanding, out_busy=%b, required 0 and 0",
                  name, exp_q.size(), out_busy);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      in_rst = 1'b1; in_valid = 1'b0; in_ready = 1'b1;
      in_num = '0; in_ctrl_op = '0; in_tag = '0;
      repeat (3) @(posedge in_clk);
      #1 in_rst = 1'b0;
      @(negedge in_clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
      checks++;
      if (out_busy !== 1'b0) begin errors++; $display("FAIL reset_out_busy: got %b, required 0", out_busy); end
      checks++;
      if (out_data !== 64'h0) begin errors++; $display("FAIL reset_out_data: got %h, required 0", out_data); end
      checks++;
      if (out_tag !== 5'h0) begin errors++; $display("FAIL reset_out_tag: got %h, required 0", out_tag); end
      checks++;
      if (out_ready !== 1'b1) begin errors++; $display("FAIL reset_out_ready: got %b, required 1", out_ready); end
      @(posedge in_clk); #1;
   endtask

   task automatic test_fclass();
      in_ready = 1'b1;
      drive_op(32'hFF800000, 2'b00, 64'h001);
      in_valid = 1'b0;
      // After the accepting edge only S1 holds the entry; the result shows
      // after the second register stage.
      @(negedge in_clk);
      checks++;
      if (out_valid !== 1'b0 || out_busy !== 1'b1) begin
         errors++;
         $display("FAIL latency_stage1: out_valid=%b out_busy=%b, required 0 and 1", out_valid, out_busy);
      end
      @(posedge in_clk); #1;
      @(negedge in_clk);
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL latency_stage2: out_valid=%b, required 1", out_valid);
      end
      @(posedge in_clk); #1;
      drive_op(32'h3F800000, 2'b00, 64'h040);
      drive_op(32'h00000001, 2'b00, 64'h020);
      drive_op(32'h80000000, 2'b00, 64'h008);
      drive_op(32'h3F800000, 2'b11, 64'h040);
      wait_drain("fclass");
   endtask

   task automatic test_nan();
      in_ready = 1'b1;
      drive_op(32'h7FC00000, 2'b00, 64'h200);
      drive_op(32'hFFC00001, 2'b00, 64'h200);
      drive_op(32'h7F800001, 2'b00, 64'h100);
      drive_op(32'h7F800000, 2'b00, 64'h080);
      drive_op(32'hFF800001, 2'b00, 64'h100);
      drive_op(32'h807FFFFF, 2'b00, 64'h004);
      drive_op(32'h00000000, 2'b00, 64'h010);
      drive_op(32'hBF800000, 2'b00, 64'h002);
      wait_drain("nan");
   endtask

   task automatic test_fmv_sign();
      in_ready = 1'b1;
      drive_op(32'hBF800000, 2'b01, 64'hFFFFFFFFBF800000);
      drive_op(32'h3F800000, 2'b01, 64'h000000003F800000);
      drive_op(32'h7FC00001, 2'b01, 64'h000000007FC00001);
      drive_op(32'h80000000, 2'b10, 64'h1);
      drive_op(32'h7FFFFFFF, 2'b10, 64'h0);
      wait_drain("fmv_sign");
   endtask

   task automatic test_back_to_back();
      logic [63:0] held;
      logic [4:0]  held_tag;
      in_ready = 1'b0;
      fork
         begin
            drive_op(32'hFF800000, 2'b00, 64'h001);
            drive_op(32'h3F800000, 2'b01, 64'h000000003F800000);
            drive_op(32'h80000000, 2'b10, 64'h1);
            drive_op(32'h7FC00000, 2'b00, 64'h200);
            in_valid = 1'b0;
         end
         begin
            // Two acceptances fill the pipe; then stall three cycles.
            repeat (2) begin @(posedge in_clk); #1; end
            @(negedge in_clk);
            held = out_data;
            held_tag = out_tag;
            checks++;
            if (out_ready !== 1'b0 || out_valid !== 1'b1) begin
               errors++;
               $display("FAIL full_stall: out_ready=%b out_valid=%b, required 0 and 1", out_ready, out_valid);
            end
            checks++;
            if (held !== 64'h001) begin
               errors++;
               $display("FAIL stall_head: out_data=%h, required 0000000000000001", held);
            end
            repeat (2) begin
               @(posedge in_clk); #1;
               @(negedge in_clk);
               checks++;
               if (out_data !== held || out_tag !== held_tag || out_ready !== 1'b0) begin
                  errors++;
                  $display("FAIL stall_hold: data %h tag %0d ready %b, required %h tag %0d ready 0",
                           out_data, out_tag, out_ready, held, held_tag);
               end
            end
            @(posedge in_clk); #1;
            in_ready = 1'b1;
         end
      join
      wait_drain("back_to_back");
   endtask

   task automatic test_random();
      logic [31:0] n;
      logic [1:0]  op;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 1) == 0) n = specials[$urandom_range(0, 7)];
         else n = $urandom;
         op         = 2'($urandom_range(0, 3));
         in_valid   = ($urandom_range(0, 2) != 0);
         in_num     = n;
         in_ctrl_op = op;
         in_tag     = tag_ctr;
         in_ready   = ($urandom_range(0, 3) != 0);
         @(negedge in_clk);
         if (in_valid && out_ready) begin
            exp_q.push_back(model(n, op));
            exp_tag_q.push_back(tag_ctr);
            tag_ctr++;
         end
         @(posedge in_clk); #1;
      end
      in_valid = 1'b0;
      wait_drain("random");
   endtask

   task automatic test_reset_mid();
      int stale = 0;
      in_ready = 1'b0;
      drive_op(32'h3F800000, 2'b00, 64'h040);
      drive_op(32'hBF800000, 2'b01, 64'hFFFFFFFFBF800000);
      in_valid = 1'b0;
      @(negedge in_clk);
      checks++;
      if (out_busy !== 1'b1 || out_ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_full: out_busy=%b out_ready=%b, required 1 and 0", out_busy, out_ready);
      end
      @(posedge in_clk); #1;
      in_rst = 1'b1;
      @(posedge in_clk); #1;
      in_rst = 1'b0;
      exp_q.delete();
      exp_tag_q.delete();
      @(negedge in_clk);
      checks++;
      if (out_valid !== 1'b0 || out_busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: out_valid=%b out_busy=%b, required 0 and 0", out_valid, out_busy);
      end
      in_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge in_clk); #1;
         @(negedge in_clk);
         if (out_valid !== 1'b0) stale++;
      end
      checks++;
      if (stale != 0) begin
         errors++;
         $display("FAIL mid_stale: %0d cycles with out_valid after reset, required 0", stale);
      end
      @(posedge in_clk); #1;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_fclass();
      test_nan();
      test_fmv_sign();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
